// File: rtl/mode_sequencer_if.sv
`default_nettype none
// ============================================================================
// mode_sequencer_if
//   Button, status and routed-pulse bundle between the mode sequencer and
//   its neighbours (debouncers/pulsers upstream, mode wrappers downstream).
//   Revision: 1.0
// ============================================================================
interface mode_sequencer_if;
  logic       pulsed_mode;
  logic       pulsed_set;
  logic       pulsed_up;
  logic       pulsed_down;
  logic       sec_tick;
  logic [3:0] edit_busy;
  logic       alarm_ring;
  logic [1:0] currentMode;
  logic [3:0] set_out;
  logic [3:0] up_out;
  logic [3:0] down_out;
  logic       mode_changed;
  logic       ring_active;
  logic       ring_ack;

  modport master (
    output pulsed_mode, pulsed_set, pulsed_up, pulsed_down, sec_tick,
           edit_busy, alarm_ring,
    input  currentMode, set_out, up_out, down_out, mode_changed,
           ring_active, ring_ack
  );

  modport slave (
    input  pulsed_mode, pulsed_set, pulsed_up, pulsed_down, sec_tick,
           edit_busy, alarm_ring,
    output currentMode, set_out, up_out, down_out, mode_changed,
           ring_active, ring_ack
  );
endinterface
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
// mode_sequencer
//   Owns the watch's active mode, routes the shared set/up/down pulses to the
//   active mode, lets a ringing alarm pre-empt the display, idles back to 0.
//   Revision: 1.0
// ============================================================================
module mode_sequencer #(
  parameter logic [3:0] MODE_EN    = 4'b1111,
  parameter logic [1:0] ALARM_MODE = 2'd1,
  parameter logic [7:0] IDLE_SECS  = 8'd30
) (
  input  logic            clk,
  input  logic            reset,
  mode_sequencer_if.slave bus
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_LOCKED = 2'd1;
  localparam logic [1:0] S_ALARM  = 2'd2;

  localparam logic [3:0] c_mode_en = MODE_EN | 4'b0001;

  logic [1:0] r_state;
  logic [1:0] r_mode;
  logic [1:0] r_saved_mode;
  logic [7:0] r_idle_cnt;
  logic       r_alarm_d;
  logic       r_pending;
  logic [3:0] r_set;
  logic [3:0] r_up;
  logic [3:0] r_down;
  logic       r_changed;
  logic       r_ring_active;
  logic       r_ring_ack;

  logic       w_alarm_rise;
  logic       w_alarm_fall;
  logic       w_btn_sud;
  logic       w_btn_any;
  logic       w_busy_cur;
  logic       w_busy_saved;
  logic [3:0] w_mode_oh;
  logic [1:0] w_state_nxt;
  logic [1:0] w_mode_nxt;
  logic [1:0] w_saved_nxt;
  logic [7:0] w_idle_nxt;
  logic       w_pending_nxt;
  logic [3:0] w_set_nxt;
  logic [3:0] w_up_nxt;
  logic [3:0] w_down_nxt;
  logic       w_ack_nxt;

  // Next enabled mode after cur, wrapping; smallest step wins.
  function automatic logic [1:0] f_next_mode(input logic [1:0] cur);
    logic [1:0] v_cand;
    f_next_mode = cur;
    for (int k = 3; k >= 1; k--) begin
      v_cand = cur + 2'(k);
      if (c_mode_en[v_cand]) f_next_mode = v_cand;
    end
  endfunction

  always_comb begin
    w_alarm_rise  = bus.alarm_ring & ~r_alarm_d;
    w_alarm_fall  = ~bus.alarm_ring & r_alarm_d;
    w_btn_sud     = bus.pulsed_set | bus.pulsed_up | bus.pulsed_down;
    w_btn_any     = w_btn_sud | bus.pulsed_mode;
    w_busy_cur    = bus.edit_busy[r_mode];
    w_busy_saved  = bus.edit_busy[r_saved_mode];
    w_mode_oh     = 4'b0001 << r_mode;

    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_saved_nxt   = r_saved_mode;
    w_idle_nxt    = r_idle_cnt;
    w_pending_nxt = r_pending;
    w_set_nxt     = 4'b0000;
    w_up_nxt      = 4'b0000;
    w_down_nxt    = 4'b0000;
    w_ack_nxt     = 1'b0;

    case (r_state)
      S_RUN: begin
        w_pending_nxt = 1'b0;
        if (w_alarm_rise || (r_pending && bus.alarm_ring)) begin
          w_saved_nxt = r_mode;
          w_mode_nxt  = ALARM_MODE;
          w_state_nxt = S_ALARM;
          w_idle_nxt  = 8'd0;
        end else if (bus.pulsed_mode) begin
          w_mode_nxt  = f_next_mode(r_mode);
          w_idle_nxt  = 8'd0;
          w_state_nxt = w_busy_cur ? S_LOCKED : S_RUN;
        end else begin
          w_set_nxt   = bus.pulsed_set  ? w_mode_oh : 4'b0000;
          w_up_nxt    = bus.pulsed_up   ? w_mode_oh : 4'b0000;
          w_down_nxt  = bus.pulsed_down ? w_mode_oh : 4'b0000;
          w_state_nxt = w_busy_cur ? S_LOCKED : S_RUN;
          if (w_btn_sud) begin
            w_idle_nxt = 8'd0;
          end else if (bus.sec_tick && (r_mode != 2'd0) && (IDLE_SECS != 8'd0)) begin
            if (r_idle_cnt == IDLE_SECS - 8'd1) begin
              w_mode_nxt = 2'd0;
              w_idle_nxt = 8'd0;
            end else begin
              w_idle_nxt = r_idle_cnt + 8'd1;
            end
          end
        end
      end

      S_LOCKED: begin
        w_set_nxt     = bus.pulsed_set  ? w_mode_oh : 4'b0000;
        w_up_nxt      = bus.pulsed_up   ? w_mode_oh : 4'b0000;
        w_down_nxt    = bus.pulsed_down ? w_mode_oh : 4'b0000;
        w_idle_nxt    = 8'd0;
        // A ring that starts mid-edit waits here, but only while it keeps ringing.
        w_pending_nxt = (r_pending | w_alarm_rise) & bus.alarm_ring;
        w_state_nxt   = w_busy_cur ? S_LOCKED : S_RUN;
      end

      S_ALARM: begin
        w_idle_nxt    = 8'd0;
        w_pending_nxt = 1'b0;
        if (w_btn_any || w_alarm_fall) begin
          w_ack_nxt   = w_btn_any;
          w_mode_nxt  = r_saved_mode;
          w_state_nxt = w_busy_saved ? S_LOCKED : S_RUN;
        end
      end

      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_mode        <= 2'd0;
      r_saved_mode  <= 2'd0;
      r_idle_cnt    <= 8'd0;
      r_alarm_d     <= 1'b0;
      r_pending     <= 1'b0;
      r_set         <= 4'b0000;
      r_up          <= 4'b0000;
      r_down        <= 4'b0000;
      r_changed     <= 1'b0;
      r_ring_active <= 1'b0;
      r_ring_ack    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mode        <= w_mode_nxt;
      r_saved_mode  <= w_saved_nxt;
      r_idle_cnt    <= w_idle_nxt;
      r_alarm_d     <= bus.alarm_ring;
      r_pending     <= w_pending_nxt;
      r_set         <= w_set_nxt;
      r_up          <= w_up_nxt;
      r_down        <= w_down_nxt;
      r_changed     <= (w_mode_nxt != r_mode);
      r_ring_active <= (w_state_nxt == S_ALARM);
      r_ring_ack    <= w_ack_nxt;
    end
  end

  assign bus.currentMode  = r_mode;
  assign bus.set_out      = r_set;
  assign bus.up_out       = r_up;
  assign bus.down_out     = r_down;
  assign bus.mode_changed = r_changed;
  assign bus.ring_active  = r_ring_active;
  assign bus.ring_ack     = r_ring_ack;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mode_sequencer
//   Directed table, hand sequences and randomized traffic for two
//   configurations of mode_sequencer against a rule-level reference model.
//   Revision: 1.0
// ============================================================================
module tb_mode_sequencer;

  typedef struct packed {
    logic       m, s, u, d, t;
    logic [3:0] busy;
    logic       ring;
  } in_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] set, up, down;
    logic       chg, ra, ack;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  typedef struct {
    int mode, saved, idle;
    bit locked, alarm, pending, prev;
  } ms_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mode_sequencer_if ifa ();
  mode_sequencer_if ifb ();

  mode_sequencer #(.MODE_EN(4'b1111), .ALARM_MODE(2'd1), .IDLE_SECS(8'd3)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  // Bit 0 deliberately left clear: the clock mode must still be reachable.
  mode_sequencer #(.MODE_EN(4'b1010), .ALARM_MODE(2'd1), .IDLE_SECS(8'd0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int errors = 0;
  ms_t        ms [2];
  logic [3:0] p_en [2] = '{4'b1111, 4'b1010};
  int         p_idle [2] = '{3, 0};
  vec_t       tv [$];

  function automatic in_t I(bit m, bit s, bit u, bit d, bit t, logic [3:0] busy, bit ring);
    in_t v;
    v.m = m; v.s = s; v.u = u; v.d = d; v.t = t; v.busy = busy; v.ring = ring;
    return v;
  endfunction

  function automatic out_t mk(int mode, logic [3:0] set, logic [3:0] up, logic [3:0] down,
                              bit chg, bit ra, bit ack);
    out_t o;
    o.mode = 2'(mode); o.set = set; o.up = up; o.down = down;
    o.chg = chg; o.ra = ra; o.ack = ack;
    return o;
  endfunction

  function automatic int next_enabled(int k, int cur);
    logic [3:0] en;
    en = p_en[k] | 4'b0001;
    for (int j = 1; j < 4; j++)
      if (en[(cur + j) % 4]) return (cur + j) % 4;
    return cur;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k].mode = 0; ms[k].saved = 0; ms[k].idle = 0;
      ms[k].locked = 0; ms[k].alarm = 0; ms[k].pending = 0; ms[k].prev = 0;
    end
  endfunction

  // One clock of behaviour, written from the mode/alarm/idle rules.
  function automatic void model_step(input int k, input in_t v, output out_t o);
    bit rise, fall, sud, anyb, take;
    int old;
    rise = v.ring && !ms[k].prev;
    fall = !v.ring && ms[k].prev;
    ms[k].prev = v.ring;
    sud  = v.s || v.u || v.d;
    anyb = sud || v.m;
    o    = '0;
    old  = ms[k].mode;
    if (ms[k].alarm) begin
      if (anyb || fall) begin
        o.ack = anyb;
        ms[k].mode = ms[k].saved;
        ms[k].alarm = 0;
        ms[k].locked = v.busy[ms[k].saved];
      end
      ms[k].idle = 0;
      ms[k].pending = 0;
    end else if (ms[k].locked) begin
      if (v.s) o.set  = 4'b0001 << old;
      if (v.u) o.up   = 4'b0001 << old;
      if (v.d) o.down = 4'b0001 << old;
      ms[k].idle = 0;
      ms[k].pending = (ms[k].pending || rise) && v.ring;
      ms[k].locked = v.busy[old];
    end else begin
      take = rise || (ms[k].pending && v.ring);
      ms[k].pending = 0;
      if (take) begin
        ms[k].saved = old;
        ms[k].mode = 1;
        ms[k].alarm = 1;
        ms[k].idle = 0;
      end else if (v.m) begin
        ms[k].mode = next_enabled(k, old);
        ms[k].idle = 0;
        ms[k].locked = v.busy[old];
      end else begin
        if (v.s) o.set  = 4'b0001 << old;
        if (v.u) o.up   = 4'b0001 << old;
        if (v.d) o.down = 4'b0001 << old;
        ms[k].locked = v.busy[old];
        if (sud) ms[k].idle = 0;
        else if (v.t && old != 0 && p_idle[k] > 0) begin
          ms[k].idle++;
          if (ms[k].idle == p_idle[k]) begin
            ms[k].mode = 0;
            ms[k].idle = 0;
          end
        end
      end
    end
    o.mode = 2'(ms[k].mode);
    o.chg  = (ms[k].mode != old);
    o.ra   = ms[k].alarm;
  endfunction

  function automatic out_t read_a();
    return {ifa.currentMode, ifa.set_out, ifa.up_out, ifa.down_out,
            ifa.mode_changed, ifa.ring_active, ifa.ring_ack};
  endfunction

  function automatic out_t read_b();
    return {ifb.currentMode, ifb.set_out, ifb.up_out, ifb.down_out,
            ifb.mode_changed, ifb.ring_active, ifb.ring_ack};
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got mode=%0d set=%b up=%b down=%b chg=%b ra=%b ack=%b, expected mode=%0d set=%b up=%b down=%b chg=%b ra=%b ack=%b",
               name, $time, got.mode, got.set, got.up, got.down, got.chg, got.ra, got.ack,
               exp.mode, exp.set, exp.up, exp.down, exp.chg, exp.ra, exp.ack);
    end
  endtask

  task automatic drive(input in_t v);
    ifa.pulsed_mode = v.m; ifa.pulsed_set = v.s; ifa.pulsed_up = v.u; ifa.pulsed_down = v.d;
    ifa.sec_tick = v.t; ifa.edit_busy = v.busy; ifa.alarm_ring = v.ring;
    ifb.pulsed_mode = v.m; ifb.pulsed_set = v.s; ifb.pulsed_up = v.u; ifb.pulsed_down = v.d;
    ifb.sec_tick = v.t; ifb.edit_busy = v.busy; ifb.alarm_ring = v.ring;
  endtask

  // Apply one cycle of inputs, clock it, compare both DUTs with the model.
  task automatic step(input in_t v);
    out_t ea, eb;
    drive(v);
    model_step(0, v, ea);
    model_step(1, v, eb);
    @(posedge clk);
    #1;
    check("model_a", read_a(), ea);
    check("model_b", read_b(), eb);
  endtask

  task automatic do_reset(input string name);
    drive('0);
    reset = 1'b0;
    #2;
    model_reset();
    check({name, "_a"}, read_a(), '0);
    check({name, "_b"}, read_b(), '0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    in_t        v;
    vec_t       r;
    logic [3:0] busy_r;
    bit         ring_r;
    int         bi;

    reset = 1'b0;
    drive('0);
    model_reset();
    #12;
    do_reset("reset_state");

    // Config B skips mode 2; idle timeout disabled.
    step(I(1,0,0,0,0,4'h0,0)); check("b_first_mode", read_b(), mk(1,0,0,0,1,0,0));
    step(I(1,0,0,0,0,4'h0,0)); check("b_skip_mode2", read_b(), mk(3,0,0,0,1,0,0));
    step(I(0,0,1,0,0,4'h0,0)); check("b_up_route", read_b(), mk(3,0,4'b1000,0,0,0,0));
    step(I(0,0,0,0,0,4'h0,0)); check("b_up_single", read_b(), mk(3,0,0,0,0,0,0));
    for (int n = 0; n < 40; n++) step(I(0,0,0,0,1,4'h0,0));
    check("b_idle_disabled", read_b(), mk(3,0,0,0,0,0,0));
    check("a_idle_to_zero", read_a(), mk(0,0,0,0,0,0,0));

    // Reset while the alarm holds the display discards the saved mode.
    for (int n = 0; n < 3; n++) step(I(1,0,0,0,0,4'h0,0));
    step(I(0,0,0,0,0,4'h0,1)); check("a_alarm_enter", read_a(), mk(1,0,0,0,1,1,0));
    @(negedge clk);
    do_reset("reset_mid_alarm");
    step(I(0,0,0,0,0,4'h0,0)); check("a_after_alarm_reset", read_a(), mk(0,0,0,0,0,0,0));

    tv.delete();
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(1,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,0); r.e = mk(1,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(3,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(0,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(1,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,1,0,0,4'h0,0); r.e = mk(1,0,2,0,0,0,0); tv.push_back(r);
    r.i = I(0,1,0,1,0,4'h0,0); r.e = mk(1,2,0,2,0,0,0); tv.push_back(r);
    r.i = I(1,0,1,0,0,4'h0,0); r.e = mk(2,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h4,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h4,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,1,0,0,0,4'h4,0); r.e = mk(2,4,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h4,1); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,1); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,1); r.e = mk(1,0,0,0,1,1,0); tv.push_back(r);
    r.i = I(0,0,0,1,0,4'h0,1); r.e = mk(2,0,0,0,1,0,1); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h4,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h4,1); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h4,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,0); r.e = mk(0,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(1,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,1,0,1,4'h0,0); r.e = mk(2,0,4,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,0); r.e = mk(0,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(1,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(3,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,1); r.e = mk(1,0,0,0,1,1,0); tv.push_back(r);
    r.i = I(0,0,0,0,1,4'h0,1); r.e = mk(1,0,0,0,0,1,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,0); r.e = mk(3,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,1); r.e = mk(1,0,0,0,1,1,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(3,0,0,0,1,0,1); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(0,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(1,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,1); r.e = mk(1,0,0,0,0,1,0); tv.push_back(r);
    r.i = I(0,1,0,0,0,4'h0,1); r.e = mk(1,0,0,0,0,0,1); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,1); r.e = mk(1,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,0); r.e = mk(1,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,1,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h4,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h4,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(0,0,0,0,0,4'h0,0); r.e = mk(2,0,0,0,0,0,0); tv.push_back(r);
    r.i = I(1,0,0,0,0,4'h0,0); r.e = mk(3,0,0,0,1,0,0); tv.push_back(r);

    foreach (tv[n]) begin
      step(tv[n].i);
      check($sformatf("table_%0d", n), read_a(), tv[n].e);
    end

    busy_r = 4'h0;
    ring_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(15) == 0) begin
        bi = int'($urandom_range(3));
        busy_r[bi] = ~busy_r[bi];
      end
      if ($urandom_range(24) == 0) ring_r = ~ring_r;
      v.m = ($urandom_range(9) == 0);
      v.s = ($urandom_range(9) == 0);
      v.u = ($urandom_range(9) == 0);
      v.d = ($urandom_range(9) == 0);
      v.t = ($urandom_range(2) == 0);
      v.busy = busy_r;
      v.ring = ring_r;
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
Top-level mode controller for the watch. It owns currentMode, which selects clock, alarm, stopwatch or timer, and shares the single pulsed set/up/down button set between the four mode wrappers. It refuses mode changes while the active mode is mid-edit. It pre-empts the display for a ringing alarm and returns to clock mode after an idle timeout. It sits between the button debouncers/pulsers and the mode wrappers.

Parameters:
MODE_EN, 4'b1111, per-mode enable mask; bit0 (clock) is forced to 1; disabled modes are skipped when cycling.
ALARM_MODE, 2'd1, mode index shown while the alarm rings.
IDLE_SECS, 8'd30, seconds without any button before returning to mode 0; 0 disables the timeout.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pulsed_mode  in  1  one-cycle mode-button pulse
pulsed_set  in  1  one-cycle set pulse
pulsed_up  in  1  one-cycle up pulse
pulsed_down  in  1  one-cycle down pulse
sec_tick  in  1  one-cycle pulse, once per real second
edit_busy  in  4  bit m = mode m is in a non-idle (edit) state
alarm_ring  in  1  level; alarm is currently ringing
currentMode  out  2  active mode index
set_out  out  4  routed set pulse, bit m to mode m
up_out  out  4  routed up pulse
down_out  out  4  routed down pulse
mode_changed  out  1  one-cycle pulse whenever currentMode changes
ring_active  out  1  high while in the ALARM state
ring_ack  out  1  one-cycle pulse when the user silences the alarm

Behaviour:
- All outputs are registered. Reset (reset=0, asynchronous) forces:
  - currentMode=0, state=RUN;
  - all routed pulses, mode_changed, ring_ack and ring_active = 0;
  - saved mode=0, idle counter=0, alarm edge register=0, pending=0.
- States:
  - RUN: normal operation.
  - LOCKED: edit_busy[currentMode]=1.
  - ALARM: alarm is ringing and has taken over the display.
- Button routing (RUN/LOCKED): a set/up/down pulse in cycle N produces the matching bit [currentMode] high in cycle N+1 for exactly one cycle. All other bits stay 0. Simultaneous set/up/down pulses are all forwarded.
- Mode button, RUN:
  - currentMode advances to the next index with MODE_EN bit = 1, wrapping 3 to 0.
  - mode_changed pulses in N+1.
  - Any set/up/down pulse in the same cycle is dropped, because mode has priority.
- Mode button, LOCKED: ignored, not forwarded. Set/up/down are routed normally.
- RUN to LOCKED when edit_busy[currentMode]=1. LOCKED to RUN when it falls. Evaluated every cycle.
- Alarm handling:
  - alarm_ring rising edge (registered edge detect) in RUN: save currentMode, set currentMode=ALARM_MODE, go to ALARM, ring_active=1, pulse mode_changed only if the mode actually differs.
  - Rising edge in LOCKED: set pending. Enter ALARM on the first cycle back in RUN, and only if alarm_ring is still high. If alarm_ring drops first, clear pending.
- In ALARM:
  - Any button pulse (mode/set/up/down) is consumed and never forwarded. It pulses ring_ack, restores the saved mode, and goes to RUN (or LOCKED if that mode is busy).
  - alarm_ring falling without a button restores the same way with no ring_ack.
  - A button and the falling edge in the same cycle: ring_ack is still pulsed.
- Idle timeout:
  - The 8-bit counter increments on sec_tick only in RUN with currentMode≠0.
  - It clears on any button pulse, on any mode change, and outside RUN.
  - When the counter reaches IDLE_SECS: currentMode=0, mode_changed pulses, counter clears.
  - A button in the same cycle as the expiring tick wins: counter clears, no timeout.
  - IDLE_SECS=0 disables the timeout entirely.
- Reset mid-ALARM discards the saved mode; currentMode returns to 0.

Test Plan:
- Reset, then three pulsed_mode pulses 5 cycles apart with MODE_EN=4'b1111 → currentMode 1,2,3, mode_changed pulses 3 times; a fourth pulse → 0.
- MODE_EN=4'b1011, currentMode=1, pulsed_mode → currentMode=3 (mode 2 skipped); pulsed_up → up_out=4'b1000 for one cycle, one cycle later.
- currentMode=2, edit_busy=4'b0100, pulsed_mode → currentMode stays 2; pulsed_set → set_out=4'b0100; drop busy, pulsed_mode → currentMode=3.
- currentMode=3, alarm_ring rises → currentMode=1, ring_active=1; pulsed_down → down_out stays 0, ring_ack pulse, currentMode=3, ring_active=0.
- currentMode=2 locked, alarm_ring rises → no change; release busy while alarm_ring=1 → ALARM entered with currentMode=1; repeat with alarm_ring dropping before release → stays 2.
- IDLE_SECS=3, currentMode=2, three sec_ticks with no buttons → currentMode=0 and mode_changed; repeat with pulsed_up on the 3rd tick → currentMode stays 2.
